// File: rtl/rip_uart_tx.sv
// rip_uart_tx: FIFO-draining UART transmitter.
// Pops one word from a fall-through FIFO read port while idle and sends it on
// `tx` as start bit, LSB-first data, optional even parity, stop bit.
// Optional feature macro: RIP_UART_TX_PARITY_EN (adds the even-parity bit).
module rip_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  r_empty,
  output logic                  r_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef RIP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    even_parity = ^word;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    bit_done_s;
`ifdef RIP_UART_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  assign bit_done_s = (clk_cnt_q == CNT_LAST);
  assign tx         = tx_q;
  assign busy       = busy_q;

  // Pop strobe: only while idle with data available and not held in reset.
  always_comb begin
    r_en = 1'b0;
    if ((state_q == S_IDLE) && !r_empty && rst_n) begin
      r_en = 1'b1;
    end else begin
      r_en = 1'b0;
    end
  end

  // State register plus datapath and output flops, all async-reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= CNT_ZERO;
      bit_idx_q <= IDX_ZERO;
      sh_q      <= {DATA_WIDTH{1'b0}};
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef RIP_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef RIP_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next-state logic: each non-idle state lasts one bit period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (r_en) state_d = S_START;
        else      state_d = S_IDLE;
      end
      S_START: begin
        if (bit_done_s) state_d = S_DATA;
        else            state_d = S_START;
      end
      S_DATA: begin
        if (bit_done_s && (bit_idx_q == IDX_LAST)) begin
`ifdef RIP_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef RIP_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done_s) state_d = S_STOP;
        else            state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (bit_done_s) state_d = S_IDLE;
        else            state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: baud counter, bit index, shift register and latched parity.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
`ifdef RIP_UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q == S_IDLE) begin
      clk_cnt_d = CNT_ZERO;
      if (r_en) begin
        // The head word is captured only here, so later FIFO writes cannot
        // disturb a frame already in flight.
        sh_d      = r_data;
        bit_idx_d = IDX_ZERO;
`ifdef RIP_UART_TX_PARITY_EN
        par_d     = even_parity(r_data);
`endif
      end else begin
        sh_d      = sh_q;
        bit_idx_d = bit_idx_q;
      end
    end else begin
      if (bit_done_s) clk_cnt_d = CNT_ZERO;
      else            clk_cnt_d = clk_cnt_q + CNT_ONE;

      if (state_q == S_START) begin
        bit_idx_d = IDX_ZERO;
      end else if ((state_q == S_DATA) && bit_done_s) begin
        sh_d      = sh_q >> 1;
        bit_idx_d = bit_idx_q + IDX_ONE;
      end else begin
        sh_d      = sh_q;
        bit_idx_d = bit_idx_q;
      end
    end
  end

  // Output decode from the upcoming state so tx/busy are registered yet
  // change on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
`ifdef RIP_UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_rip_uart_tx.sv
// Testbench for rip_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4). Works with and
// without RIP_UART_TX_PARITY_EN defined.
module tb_rip_uart_tx;

  localparam int DW = 8;
  localparam int C  = 4;
`ifdef RIP_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NSLOT = 2 + DW + P;
  localparam int F     = NSLOT * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r_data;
  logic       r_empty;
  logic       r_en;
  logic       tx;
  logic       busy;

  always #5 clk = ~clk;

  rip_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .r_data(r_data), .r_empty(r_empty),
    .r_en(r_en), .tx(tx), .busy(busy)
  );

  // data, transmit order written first-sent-leftmost, expected even parity
  typedef struct {
    logic [7:0] data;
    logic [7:0] order;
    logic       par;
  } vec_t;
  vec_t tbl[8];

  logic [7:0] fq[$];      // FIFO contents (head at index 0)
  logic       exp_q[$];   // expected tx level for each upcoming busy cycle
  int         pop_cyc[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       last_tx, last_busy, last_ren;
  bit         pend_pop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    r_empty = (fq.size() == 0);
    r_data  = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    drive_fifo();
  endtask

  // One clock cycle: check DUT against the frame-level model at the falling
  // edge, then advance the FIFO model after the rising edge.
  task automatic step();
    logic e_busy, e_tx, e_ren, popped;
    logic [7:0] w;
    @(negedge clk);
    e_busy = rst_n && (exp_q.size() > 0);
    e_tx   = e_busy ? exp_q[0] : 1'b1;
    e_ren  = rst_n && !e_busy && (fq.size() > 0);
    chk($sformatf("model_tx@%0d", cyc), tx, e_tx);
    chk($sformatf("model_busy@%0d", cyc), busy, e_busy);
    chk($sformatf("model_ren@%0d", cyc), r_en, e_ren);
    last_tx = tx; last_busy = busy; last_ren = r_en;
    if (r_en) pop_cyc.push_back(cyc);
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    popped = 1'b0;
    if (e_ren) begin
      w = fq[0];
      popped = 1'b1;
      for (int s = 0; s < NSLOT; s++) begin
        logic b;
        if (s == 0)                   b = 1'b0;
        else if (s <= DW)             b = w[s-1];
        else if (P == 1 && s == DW+1) b = ^w;
        else                          b = 1'b1;
        repeat (C) exp_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    if (popped) void'(fq.pop_front());
    drive_fifo();
    cyc++;
  endtask

  task automatic wait_pop(input int max_steps, output int waited, output bit got);
    waited = 0;
    got = 1'b0;
    if (pend_pop) begin
      got = 1'b1;
      pend_pop = 1'b0;
    end
    while (!got && waited < max_steps) begin
      step();
      if (last_ren) got = 1'b1;
      else waited++;
    end
  endtask

  // Capture one whole frame after its pop and compare slot by slot.
  task automatic run_frame(input vec_t v, input int max_wait, output int waited);
    bit   got;
    int   nb;
    logic cap[$];
    wait_pop(max_wait, waited, got);
    chk($sformatf("pop_seen %02h", v.data), got, 1'b1);
    if (!got) return;
    nb = 0;
    for (int i = 0; i < F; i++) begin
      step();
      cap.push_back(last_tx);
      if (last_busy) nb++;
    end
    chk($sformatf("busy_cycles %02h", v.data), nb, F);
    for (int s = 0; s < NSLOT; s++) begin
      logic         e;
      logic [C-1:0] act;
      if (s == 0)                   e = 1'b0;
      else if (s <= DW)             e = v.order[DW-s];
      else if (P == 1 && s == DW+1) e = v.par;
      else                          e = 1'b1;
      for (int j = 0; j < C; j++) act[j] = cap[s*C+j];
      chk($sformatf("frame %02h slot %0d", v.data, s), act, {C{e}});
    end
    step();
    chk($sformatf("gap_tx %02h", v.data), last_tx, 1'b1);
    chk($sformatf("gap_busy %02h", v.data), last_busy, 1'b0);
    if (last_ren) pend_pop = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, nren, nlow, k;
    bit   got;
    vec_t v81;
    tbl[0] = '{8'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{8'h07, 8'b11100000, 1'b1};
    tbl[2] = '{8'h00, 8'b00000000, 1'b0};
    tbl[3] = '{8'hFF, 8'b11111111, 1'b0};
    tbl[4] = '{8'h55, 8'b10101010, 1'b0};
    tbl[5] = '{8'h01, 8'b10000000, 1'b1};
    tbl[6] = '{8'h80, 8'b00000001, 1'b1};
    tbl[7] = '{8'h81, 8'b10000001, 1'b0};

    // Reset held with data waiting
    drive_fifo();
    push(tbl[0].data);
    repeat (3) step();
    chk("rst_tx", last_tx, 1'b1);
    chk("rst_busy", last_busy, 1'b0);
    chk("rst_ren", last_ren, 1'b0);
    rst_n = 1'b1;
    run_frame(tbl[0], 5, w);
    chk("first_pop_delay", w, 0);

    // Single frame 0x07
    push(tbl[1].data);
    run_frame(tbl[1], 5, w);

    // Back-to-back frames
    pop_cyc.delete();
    push(tbl[2].data); push(tbl[3].data); push(tbl[4].data);
    run_frame(tbl[2], 5, w);
    run_frame(tbl[3], 5, w);
    chk("b2b_wait1", w, 0);
    run_frame(tbl[4], 5, w);
    chk("b2b_wait2", w, 0);
    chk("b2b_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() >= 3) begin
      chk("b2b_spacing01", pop_cyc[1] - pop_cyc[0], F + 1);
      chk("b2b_spacing12", pop_cyc[2] - pop_cyc[1], F + 1);
    end

    // Remaining table frames
    for (int i = 5; i < 7; i++) begin
      push(tbl[i].data);
      run_frame(tbl[i], 5, w);
    end

    // Empty FIFO for 100 cycles
    nren = 0; nlow = 0;
    repeat (100) begin
      step();
      if (last_ren) nren++;
      if (!last_tx) nlow++;
    end
    chk("empty_ren_count", nren, 0);
    chk("empty_tx_low_count", nlow, 0);

    // Reset during data bit 3 of 0x3C, then 0x81 must follow cleanly
    push(8'h3C);
    wait_pop(5, w, got);
    chk("mid_pop_seen", got, 1'b1);
    repeat (17) step();
    chk("mid_pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    push(tbl[7].data);
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ren", r_en, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    v81 = tbl[7];
    run_frame(v81, 3, w);
    chk("mid_post_pop_delay", w, 0);

    // Random traffic against the frame-level model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(1, 3)) push(8'($urandom));
      end
      step();
    end
    k = 0;
    while ((fq.size() > 0 || exp_q.size() > 0) && k < 3000) begin
      step();
      k++;
    end
    chk("drain_left", fq.size() + exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
